// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller with optional misaligned-access splitting
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [2:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [4:0]        rd_i,
    output logic              req_o,
    input  logic              gnt_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic [3:0]        be_o,
    output logic [31:0]       wdata_o,
    input  logic              rvalid_i,
    input  logic [31:0]       rdata_i,
    output logic              valid_o,
    output logic [4:0]        rd_o,
    output logic [31:0]       rdata_o,
    output logic              wb_en_o,
    output logic              err_o
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2} state_t;

    state_t            state;
    state_t            state_nxt;

    logic              accept;
    logic              size_ok;
    logic              misaligned;
    logic              reject;

    logic              we_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic              split_q;
    logic [31:0]       beat1_q;

    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        base_mask;
    logic [7:0]        mask_ext;
    logic [63:0]       wdata_ext;
    logic              second;

    logic              final_beat;
    logic [55:0]       raw;
    logic [31:0]       load_word;
    logic [31:0]       load_val;

    assign ready_o = (state == IDLE);
    assign accept  = valid_i && ready_o;

    // Classify the incoming request: legal size, and natural alignment for H/W
    always_comb begin
        size_ok    = 1'b0;
        misaligned = 1'b0;
        case (size_i)
            3'b000, 3'b100: size_ok = 1'b1;
            3'b001, 3'b101: begin
                size_ok    = 1'b1;
                misaligned = addr_i[0];
            end
            3'b010: begin
                size_ok    = 1'b1;
                misaligned = (addr_i[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Requests that never touch memory and complete immediately with an error
    assign reject = !size_ok || (misaligned && (MISALIGN_EN == 0));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stray gnt/rvalid in the wrong state fall through unchanged
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !reject) state_nxt = REQ1;
            REQ1:    if (gnt_i) state_nxt = WAIT1;
            WAIT1:   if (rvalid_i) state_nxt = split_q ? REQ2 : IDLE;
            REQ2:    if (gnt_i) state_nxt = WAIT2;
            WAIT2:   if (rvalid_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture request fields on acceptance and the first beat of a split load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rd_q    <= 5'h0;
            split_q <= 1'b0;
            beat1_q <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= we_i;
                size_q  <= size_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                rd_q    <= rd_i;
                split_q <= misaligned;
            end
            if (state == WAIT1 && rvalid_i) begin
                beat1_q <= rdata_i;
            end
        end
    end

    // Byte mask of the access before lane placement
    always_comb begin
        base_mask = 4'b1111;
        case (size_q[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    end

    // Lane placement: the low half feeds beat 1, whatever spills past lane 3 feeds beat 2
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign mask_ext  = {4'b0000, base_mask} << addr_q[1:0];
    assign wdata_ext = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    assign second    = (state == REQ2);

    assign req_o   = (state == REQ1) || second;
    assign we_o    = req_o && we_q;
    assign addr_o  = !req_o ? '0 : (second ? word_addr + ADDR_W'(4) : word_addr);
    assign be_o    = !req_o ? 4'b0000 : (second ? mask_ext[7:4] : mask_ext[3:0]);
    assign wdata_o = !req_o ? 32'h0 : (second ? wdata_ext[63:32] : wdata_ext[31:0]);

    // Response alignment: beat 2 bytes sit above beat 1; an offset of at most 3 bytes
    // means the top byte of beat 2 can never reach the result
    assign final_beat = rvalid_i && (((state == WAIT1) && !split_q) || (state == WAIT2));
    assign raw        = (state == WAIT2) ? {rdata_i[23:0], beat1_q} : {24'h0, rdata_i};
    assign load_word  = raw[{addr_q[1:0], 3'b000} +: 32];

    // Sign/zero extension by access size
    always_comb begin
        load_val = load_word;
        case (size_q)
            3'b000:  load_val = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_val = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_val = {24'h0, load_word[7:0]};
            3'b101:  load_val = {16'h0, load_word[15:0]};
            default: load_val = load_word;
        endcase
    end

    // Completion channel: one-cycle pulse, all fields zero otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            wb_en_o <= 1'b0;
            rd_o    <= 5'h0;
            rdata_o <= 32'h0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            wb_en_o <= 1'b0;
            rd_o    <= 5'h0;
            rdata_o <= 32'h0;
            if (accept && reject) begin
                valid_o <= 1'b1;
                err_o   <= 1'b1;
                rd_o    <= rd_i;
            end else if (final_beat) begin
                valid_o <= 1'b1;
                rd_o    <= rd_q;
                wb_en_o <= !we_q;
                rdata_o <= we_q ? 32'h0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl against a byte-level model
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        va = 1'b0, vb = 1'b0;
    logic        ga = 1'b0, gb = 1'b0;
    logic        rva = 1'b0, rvb = 1'b0;
    logic        t_we = 1'b0;
    logic [2:0]  t_size = 3'b000;
    logic [31:0] t_addr = 32'h0;
    logic [31:0] t_wdata = 32'h0;
    logic [4:0]  t_rd = 5'h0;
    logic [31:0] t_rdata = 32'h0;

    logic        ready_a, req_a, we_a, valid_a, wb_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;
    logic [4:0]  rd_a;
    logic        ready_b, req_b, we_b, valid_b, wb_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;
    logic [4:0]  rd_b;

    logic        sel = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .MISALIGN_EN(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(va), .ready_o(ready_a), .we_i(t_we),
        .size_i(t_size), .addr_i(t_addr), .wdata_i(t_wdata), .rd_i(t_rd),
        .req_o(req_a), .gnt_i(ga), .addr_o(addr_a), .we_o(we_a), .be_o(be_a),
        .wdata_o(wdata_a), .rvalid_i(rva), .rdata_i(t_rdata), .valid_o(valid_a),
        .rd_o(rd_a), .rdata_o(rdata_a), .wb_en_o(wb_a), .err_o(err_a)
    );

    lsu_ctrl #(.ADDR_W(32), .MISALIGN_EN(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(vb), .ready_o(ready_b), .we_i(t_we),
        .size_i(t_size), .addr_i(t_addr), .wdata_i(t_wdata), .rd_i(t_rd),
        .req_o(req_b), .gnt_i(gb), .addr_o(addr_b), .we_o(we_b), .be_o(be_b),
        .wdata_o(wdata_b), .rvalid_i(rvb), .rdata_i(t_rdata), .valid_o(valid_b),
        .rd_o(rd_b), .rdata_o(rdata_b), .wb_en_o(wb_b), .err_o(err_b)
    );

    logic        m_ready, m_req, m_we, m_valid, m_wb, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic [4:0]  m_rd;
    assign m_ready = sel ? ready_b : ready_a;
    assign m_req   = sel ? req_b   : req_a;
    assign m_we    = sel ? we_b    : we_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_wb    = sel ? wb_b    : wb_a;
    assign m_err   = sel ? err_b   : err_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_wdata = sel ? wdata_b : wdata_a;
    assign m_rdata = sel ? rdata_b : rdata_a;
    assign m_be    = sel ? be_b    : be_a;
    assign m_rd    = sel ? rd_b    : rd_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) vb = v; else va = v;
    endtask

    task automatic set_gnt(input logic v);
        if (sel) gb = v; else ga = v;
    endtask

    task automatic set_rvalid(input logic v);
        if (sel) rvb = v; else rva = v;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, m_ready, 1);
        check({tag, "_req"},   m_req, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_rdata"}, m_rdata, 0);
        check({tag, "_err"},   m_err, 0);
        check({tag, "_wb"},    m_wb, 0);
    endtask

    // One access on the selected unit; the memory side answers with words d1 then d2
    task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input int max_dly, output logic [31:0] got);
        int          nbytes, nbeats, p, bt, ln;
        logic        supported, misal, reject;
        logic [31:0] exp_addr [2];
        logic [3:0]  exp_be [2];
        logic [31:0] exp_wd [2];
        logic [31:0] exp_data;
        logic [7:0]  b;

        supported = (size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        nbytes    = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
        misal     = supported && ((int'(addr[1:0]) % nbytes) != 0);
        reject    = !supported || (misal && sel);
        nbeats    = misal ? 2 : 1;

        exp_addr[0] = addr & ~32'h3;
        exp_addr[1] = (addr & ~32'h3) + 32'd4;
        exp_be[0] = 4'b0; exp_be[1] = 4'b0;
        exp_wd[0] = 32'h0; exp_wd[1] = 32'h0;
        for (int j = 0; j < 4; j++) begin
            p  = int'(addr[1:0]) + j;
            bt = p / 4;
            ln = p % 4;
            exp_wd[bt][8*ln +: 8] = wdata[8*j +: 8];
            if (j < nbytes) exp_be[bt][ln] = 1'b1;
        end
        exp_data = 32'h0;
        for (int j = 0; j < nbytes; j++) begin
            p = int'(addr[1:0]) + j;
            b = (p < 4) ? d1[8*p +: 8] : d2[8*(p-4) +: 8];
            exp_data[8*j +: 8] = b;
        end
        if (!size[2] && nbytes < 4 && exp_data[8*nbytes-1]) begin
            for (int j = nbytes; j < 4; j++) exp_data[8*j +: 8] = 8'hFF;
        end
        if (we) exp_data = 32'h0;

        got = 32'h0;
        @(negedge clk);
        check("ready_idle", m_ready, 1);
        t_we = we; t_size = size; t_addr = addr; t_wdata = wdata; t_rd = rd;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
        t_we = ~we; t_addr = $urandom; t_wdata = $urandom; t_rd = 5'($urandom);
        t_size = 3'($urandom);

        if (reject) begin
            check("rej_valid", m_valid, 1);
            check("rej_err",   m_err, 1);
            check("rej_rd",    m_rd, rd);
            check("rej_wb",    m_wb, 0);
            check("rej_req",   m_req, 0);
            @(negedge clk);
            check("rej_valid_end", m_valid, 0);
            check("rej_req_end",   m_req, 0);
            return;
        end

        for (int k = 0; k < nbeats; k++) begin
            int dly;
            dly = $urandom_range(0, max_dly);
            for (int c = 0; c <= dly; c++) begin
                check("req",   m_req, 1);
                check("addr",  m_addr, exp_addr[k]);
                check("be",    m_be, exp_be[k]);
                check("wdata", m_wdata, exp_wd[k]);
                check("we",    m_we, we);
                check("valid_in_req", m_valid, 0);
                if (c == dly) begin
                    set_gnt(1'b1); set_rvalid(1'b0);
                end else begin
                    set_gnt(1'b0); set_rvalid(1'($urandom)); t_rdata = $urandom;
                end
                @(negedge clk);
            end
            set_gnt(1'b0); set_rvalid(1'b0);
            dly = $urandom_range(0, max_dly);
            for (int c = 0; c <= dly; c++) begin
                check("req_in_wait",   m_req, 0);
                check("valid_in_wait", m_valid, 0);
                if (c == dly) begin
                    set_gnt(1'b0); set_rvalid(1'b1); t_rdata = (k == 0) ? d1 : d2;
                end else begin
                    set_gnt(1'($urandom)); set_rvalid(1'b0);
                end
                @(negedge clk);
            end
            set_gnt(1'b0); set_rvalid(1'b0);
        end

        check("done_valid", m_valid, 1);
        check("done_rd",    m_rd, rd);
        check("done_wb",    m_wb, !we);
        check("done_err",   m_err, 0);
        check("done_rdata", m_rdata, exp_data);
        got = m_rdata;
        @(negedge clk);
        check("pulse_valid", m_valid, 0);
        check("pulse_rdata", m_rdata, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [2:0]  sz;
        logic [31:0] ad;

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_quiet("rst");
            check("rst_addr",  m_addr, 0);
            check("rst_be",    m_be, 0);
            check("rst_wdata", m_wdata, 0);
            check("rst_rd",    m_rd, 0);
            check("rst_we",    m_we, 0);
        end
        sel = 1'b0;
        rst = 1'b0;

        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 32'hDEADBEEF, 32'h0, 0, got);
        check("lw_aligned", got, 32'hDEADBEEF);
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd2, 32'h80112233, 32'h0, 0, got);
        check("lb_sext", got, 32'hFFFFFF80);
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 5'd3, 32'h80112233, 32'h0, 0, got);
        check("lbu_zext", got, 32'h00000080);
        run_txn(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd4, 32'h0, 32'h0, 0, got);
        run_txn(1'b0, 3'b010, 32'h0FF, 32'h0, 5'd5, 32'h44A5A5A5, 32'h5A332211, 1, got);
        check("lw_split", got, 32'h33221144);
        sel = 1'b1;
        run_txn(1'b0, 3'b010, 32'h0FF, 32'h0, 5'd6, 32'h44A5A5A5, 32'h5A332211, 1, got);
        run_txn(1'b0, 3'b011, 32'h200, 32'h0, 5'd7, 32'h0, 32'h0, 0, got);
        sel = 1'b0;
        run_txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd8, 32'h2211AAAA, 32'hBBBB4433, 1, got);
        check("lw_wrap", got, 32'h44332211);

        // Reset while waiting for the response, then a late response
        @(negedge clk);
        t_we = 1'b0; t_size = 3'b010; t_addr = 32'h200; t_rd = 5'd9;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0); set_gnt(1'b1);
        @(negedge clk);
        set_gnt(1'b0);
        check("pre_rst_req", m_req, 0);
        rst = 1'b1;
        #1;
        check("midrst_ready", m_ready, 1);
        check("midrst_req",   m_req, 0);
        @(negedge clk);
        rst = 1'b0;
        set_rvalid(1'b1); t_rdata = 32'h12345678;
        @(negedge clk);
        set_rvalid(1'b0);
        check_quiet("late_rvalid");
        @(negedge clk);
        check_quiet("late_rvalid2");

        for (int i = 0; i < 300; i++) begin
            sel = 1'($urandom);
            sz  = 3'($urandom);
            if ($urandom_range(0, 3) == 0) ad = 32'hFFFFFFF0 + ($urandom % 16);
            else ad = $urandom;
            run_txn(1'($urandom), sz, ad, $urandom, 5'($urandom), $urandom, $urandom, 2, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
